// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle operand-2 generator for an ARM-style datapath.
// A request is sampled in IDLE. The work register W is then shifted or rotated
// by its count C over successive SHIFT cycles, and the result is published on
// val2_out together with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           request, sampled only in IDLE
//   flush           synchronous cancel, returns to IDLE without done
//   shifter_operand 12-bit operand-2 field
//   imm             rotated 8-bit immediate form
//   is_for_memory   12-bit load/store offset form (highest priority)
//   val_Rm          Rm register value
//   busy            state != IDLE
//   done            one-cycle pulse; val2_out is valid from this cycle on
//   val2_out        registered result, held until the next done
//
// Build option: define SHIFT_STEP4_EN to retire up to 4 shift positions per
// SHIFT cycle. Results are identical; only the latency changes.
module shift_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [11:0] shifter_operand,
  input  logic        imm,
  input  logic        is_for_memory,
  input  logic [31:0] val_Rm,
  output logic        busy,
  output logic        done,
  output logic [31:0] val2_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {OP_LSL = 2'd0, OP_LSR = 2'd1, OP_ASR = 2'd2, OP_ROR = 2'd3} shop_t;

  typedef struct packed {
    logic [31:0] w;
    logic [4:0]  c;
    shop_t       op;
  } work_t;

  state_t      state, state_nxt;
  work_t       cur, ld;
  logic        load, shift_en, val2_ld;
  logic [31:0] val2_nxt, w_sh;
  logic [4:0]  c_nxt;
  logic [2:0]  step;

  // Shift or rotate by n positions. The doubled word gives the rotate for free.
  function automatic logic [31:0] shift_by(input logic [31:0] w, input shop_t op,
                                           input logic [2:0] n);
    logic [63:0] dbl;
    dbl = {w, w} >> n;
    case (op)
      OP_LSL:  return w << n;
      OP_LSR:  return w >> n;
      OP_ASR:  return 32'($signed(w) >>> n);
      default: return dbl[31:0];
    endcase
  endfunction

  // Operand decode; priority is memory > immediate > register.
  always_comb begin
    ld = '0;
    if (is_for_memory) begin
      ld.w  = {20'd0, shifter_operand};
      ld.c  = 5'd0;
      ld.op = OP_LSL;
    end else if (imm) begin
      ld.w  = {24'd0, shifter_operand[7:0]};
      ld.c  = {shifter_operand[11:8], 1'b0};
      ld.op = OP_ROR;
    end else begin
      ld.w  = val_Rm;
      ld.c  = shifter_operand[11:7];
      ld.op = shop_t'(shifter_operand[6:5]);
    end
  end

`ifdef SHIFT_STEP4_EN
  assign step = (cur.c > 5'd4) ? 3'd4 : cur.c[2:0];
`else
  assign step = 3'd1;
`endif

  assign w_sh  = shift_by(cur.w, cur.op, step);
  assign c_nxt = cur.c - {2'b00, step};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    val2_ld   = 1'b0;
    val2_nxt  = w_sh;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          load = 1'b1;
          if (ld.c == 5'd0) begin
            // Zero count: the loaded operand is already the result.
            state_nxt = DONE;
            val2_ld   = 1'b1;
            val2_nxt  = ld.w;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          shift_en = 1'b1;
          if (c_nxt == 5'd0) begin
            state_nxt = DONE;
            val2_ld   = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      val2_out <= '0;
    end else begin
      if (load) begin
        cur <= ld;
      end else if (shift_en) begin
        cur.w <= w_sh;
        cur.c <= c_nxt;
      end
      if (val2_ld) val2_out <= val2_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases, randomized
// operations against a whole-word arithmetic model, flush, mid-op reset and
// back-to-back throughput.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, imm, is_for_memory;
  logic [11:0] shifter_operand;
  logic [31:0] val_Rm;
  logic        busy, done;
  logic [31:0] val2_out;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_done, last_lat;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .shifter_operand(shifter_operand), .imm(imm), .is_for_memory(is_for_memory),
    .val_Rm(val_Rm), .busy(busy), .done(done), .val2_out(val2_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int a);
    if (a == 0) return x;
    return (x >> a) | (x << (32 - a));
  endfunction

  // Expected result and shift amount straight from the operand encoding.
  task automatic model(input logic [11:0] so, input logic im, input logic mem,
                       input logic [31:0] rm, output logic [31:0] v, output int a);
    logic [1:0] op;
    op = so[6:5];
    if (mem) begin
      v = {20'd0, so};
      a = 0;
    end else if (im) begin
      a = 2 * int'(so[11:8]);
      v = rotr({24'd0, so[7:0]}, a);
    end else begin
      a = int'(so[11:7]);
      case (op)
        2'd0:    v = rm << a;
        2'd1:    v = rm >> a;
        2'd2:    v = $signed(rm) >>> a;
        default: v = rotr(rm, a);
      endcase
    end
  endtask

  function automatic int exp_lat(input int a);
`ifdef SHIFT_STEP4_EN
    return (a + 3) / 4 + 1;
`else
    return a + 1;
`endif
  endfunction

  // Runs one operation from an IDLE cycle. Inputs are scrambled and start is
  // pulsed while busy, so a correct result also shows the operands were held.
  // Entered and left at posedge+1.
  task automatic run_op(input logic [11:0] so, input logic im, input logic mem,
                        input logic [31:0] rm, input string tag);
    logic [31:0] ev;
    int amt, el, lat;
    bit busy_ok;
    model(so, im, mem, rm, ev, amt);
    el = exp_lat(amt);
    shifter_operand = so; imm = im; is_for_memory = mem; val_Rm = rm;
    flush = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 80) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = 1'($urandom_range(0, 1));
      shifter_operand = 12'($urandom); imm = 1'($urandom); is_for_memory = 1'($urandom);
      val_Rm = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    last_done = cyc;
    last_lat  = lat;
    checks++;
    if (done !== 1'b1 || lat != el) begin
      fails++;
      $display("FAIL %s latency: got %0d (done=%b) expected %0d", tag, lat, done, el);
    end
    checks++;
    if (val2_out !== ev) begin
      fails++;
      $display("FAIL %s value: got %h expected %h", tag, val2_out, ev);
    end
    checks++;
    if (!busy_ok || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_during_op: busy dropped, expected high", tag);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || val2_out !== ev) begin
      fails++;
      $display("FAIL %s after_done: done=%b busy=%b val=%h expected 0 0 %h",
               tag, done, busy, val2_out, ev);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; imm = 1'b0; is_for_memory = 1'b0;
    shifter_operand = '0; val_Rm = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || val2_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b val=%h expected 0 0 0", busy, done, val2_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(12'h2FF, 1'b1, 1'b0, 32'h0, "imm_2ff");
    checks++;
`ifdef SHIFT_STEP4_EN
    if (val2_out !== 32'hF000000F || last_lat != 2) begin
`else
    if (val2_out !== 32'hF000000F || last_lat != 5) begin
`endif
      fails++;
      $display("FAIL imm_2ff_const: got %h lat %0d", val2_out, last_lat);
    end
    run_op(12'hF80, 1'b0, 1'b0, 32'h1, "lsl31");
    checks++;
`ifdef SHIFT_STEP4_EN
    if (val2_out !== 32'h80000000 || last_lat != 9) begin
`else
    if (val2_out !== 32'h80000000 || last_lat != 32) begin
`endif
      fails++;
      $display("FAIL lsl31_const: got %h lat %0d", val2_out, last_lat);
    end
    run_op(12'h240, 1'b0, 1'b0, 32'h80000000, "asr4");
    checks++;
    if (val2_out !== 32'hF8000000) begin
      fails++;
      $display("FAIL asr4_const: got %h expected f8000000", val2_out);
    end
    run_op(12'h460, 1'b0, 1'b0, 32'h12345678, "ror8");
    checks++;
    if (val2_out !== 32'h78123456) begin
      fails++;
      $display("FAIL ror8_const: got %h expected 78123456", val2_out);
    end
    run_op(12'hABC, 1'b1, 1'b1, 32'hFFFFFFFF, "mem_abc");
    checks++;
    if (val2_out !== 32'h00000ABC || last_lat != 1) begin
      fails++;
      $display("FAIL mem_abc_const: got %h lat %0d expected 00000abc lat 1", val2_out, last_lat);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(12'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom, "rand");
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    bit seen;
    run_op(12'h460, 1'b0, 1'b0, 32'h12345678, "pre_flush");
    prior = 32'h78123456;
    shifter_operand = 12'hF80; imm = 1'b0; is_for_memory = 1'b0; val_Rm = 32'h1;
    start = 1'b1;
    @(posedge clk); #1;          // SHIFT cycle 1
    start = 1'b0;
    @(posedge clk); #1;          // SHIFT cycle 2: start pulse while busy
    start = 1'b1;
    @(posedge clk); #1;          // SHIFT cycle 3: flush
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || val2_out !== prior) begin
      fails++;
      $display("FAIL flush_to_idle: busy=%b done=%b val=%h expected 0 0 %h",
               busy, done, val2_out, prior);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL flush_no_done: activity seen after flush, expected none");
    end
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || val2_out !== prior) begin
      fails++;
      $display("FAIL flush_over_start: busy=%b val=%h expected 0 %h", busy, val2_out, prior);
    end
  endtask

  task automatic test_rst_mid();
    shifter_operand = 12'hF80; imm = 1'b0; is_for_memory = 1'b0; val_Rm = 32'h1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || val2_out !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid_async: busy=%b done=%b val=%h expected 0 0 0", busy, done, val2_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Start sampled on the first edge after release; latency check also
    // shows no leftover done from the discarded operation.
    run_op(12'h2FF, 1'b1, 1'b0, 32'h0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [11:0] so;
    logic [31:0] ev;
    int amt;
    for (int i = 0; i < 4; i++) begin
      run_op(12'($urandom), 1'b0, 1'b0, $urandom, "b2b_a");
      t0 = last_done;
      so = 12'($urandom);
      model(so, 1'b0, 1'b0, 32'h0, ev, amt);
      run_op(so, 1'b0, 1'b0, $urandom, "b2b_b");
      checks++;
      if (last_done - t0 != exp_lat(amt) + 1) begin
        fails++;
        $display("FAIL b2b_interval: got %0d expected %0d", last_done - t0, exp_lat(amt) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a new operand-2 computation; sampled only in IDLE.
REQ-004 SHALL have port flush  input  1  synchronous cancel of any in-flight computation.
REQ-005 SHALL have port shifter_operand  input  12  instruction operand-2 field.
REQ-006 SHALL have port imm  input  1  1 = rotated 8-bit immediate form.
REQ-007 SHALL have port is_for_memory  input  1  1 = 12-bit load/store offset form.
REQ-008 SHALL have port val_Rm  input  32  Rm register value.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; val2_out is valid from this cycle.
REQ-011 SHALL have port val2_out  output  32  registered result, held until the next done.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and DONE, encoded in a 2-bit register.
REQ-013 SHALL, in IDLE with start=1 and flush=0, capture the operands, then load the work register W and the 5-bit count C.
REQ-014 SHALL select the mode with priority is_for_memory > imm > register, matching the instruction decoder.
REQ-015 SHALL, for memory mode, load W = zero-extended shifter_operand with C=0.
REQ-016 SHALL, for imm mode, load W = zero-extended shifter_operand[7:0] with C = {shifter_operand[11:8],0}, and apply the ROR operation.
REQ-017 SHALL, for register mode, load W=val_Rm with C=shifter_operand[11:7], and take the operation from shifter_operand[6:5]: 00 LSL, 01 LSR, 10 ASR (sign-replicating), 11 ROR.
REQ-018 SHALL treat C=0 as no shift for every operation; the ARM amount-0 special encodings are not supported.
REQ-019 SHALL transition IDLE->DONE when the loaded C=0, and IDLE->SHIFT otherwise.
REQ-020 SHALL, in each SHIFT cycle, shift or rotate W by one bit position and decrement C.
REQ-021 SHALL transition SHIFT->DONE on the edge where C reaches 0, loading val2_out with the final W on that same edge.
REQ-022 SHALL assert done for exactly the one DONE cycle, then return DONE->IDLE unconditionally.
REQ-023 SHALL give a latency, from the start-sampling edge to done high, of C+1 cycles (C=0 gives 1 cycle).
REQ-024 SHALL ignore start while busy=1; captured operands are not altered mid-operation.
REQ-025 SHALL, when flush=1 in any state, move to IDLE on the next edge with no done pulse and val2_out unchanged.
REQ-026 SHALL give flush priority over start in IDLE; the request is dropped.
REQ-027 SHALL accept a start in the cycle after DONE, i.e. in IDLE; back-to-back throughput is therefore C+2 cycles per operation.
REQ-028 SHALL keep all arithmetic 32-bit, with ASR replicating W[31] and ROR feeding W[0] into W[31].

Reset
REQ-029 SHALL, on rst=1 and independent of clk, force state=IDLE, busy=0, done=0, val2_out=0, W=0 and C=0.
REQ-030 SHALL, on rst asserted mid-operation, discard the computation and produce no done after release.
REQ-031 SHALL sample start on the first rising edge after rst deasserts.

Configuration
REQ-032 SHALL support the macro SHIFT_STEP4_EN.
REQ-033 SHALL, when SHIFT_STEP4_EN is defined, shift W by min(4,C) positions per SHIFT cycle and subtract the same value from C, giving a latency of ceil(C/4)+1 cycles.
REQ-034 SHALL, when SHIFT_STEP4_EN is undefined, implement only the 1-bit-per-cycle datapath.
REQ-035 SHALL produce identical val2_out values with and without SHIFT_STEP4_EN.

Verification
REQ-036 SHALL cover imm=1, shifter_operand=0x2FF -> val2_out=0xF000000F with done 5 cycles after start (2 with SHIFT_STEP4_EN).
REQ-037 SHALL cover register mode, shifter_operand=0xF80 (LSL 31), val_Rm=0x00000001 -> 0x80000000 after 32 cycles (9 with SHIFT_STEP4_EN); busy high throughout.
REQ-038 SHALL cover register mode, 0x240 (ASR 4), val_Rm=0x80000000 -> 0xF8000000; then 0x460 (ROR 8), val_Rm=0x12345678 -> 0x78123456.
REQ-039 SHALL cover is_for_memory=1, shifter_operand=0xABC -> 0x00000ABC, with done 1 cycle after start and imm ignored.
REQ-040 SHALL cover flush on the 3rd SHIFT cycle of LSL 31 -> IDLE next edge, no done, val2_out keeps its prior value, and a start pulsed while busy is ignored.
REQ-041 SHALL cover rst asserted mid-SHIFT -> all outputs 0 immediately, and a start after release completes normally.
